// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants and helpers for the TPU instruction path.
//   INSTR_TYPE_W      - width of one TPU instruction word (instr_type)
//   DEFAULT_SEG_WIDTH - default width of one host-written segment
//   seg_count()       - number of segments needed to cover an instruction
package tpu_pkg;

   localparam int INSTR_TYPE_W      = 80;
   localparam int DEFAULT_SEG_WIDTH = 32;

   typedef logic [INSTR_TYPE_W-1:0] instr_type;

   // ceil(iw/sw)
   function automatic int seg_count(int iw, int sw);
      return (iw + sw - 1) / sw;
   endfunction

endpackage

// File: rtl/instr_assembler.sv
// instr_assembler: collects independently written segments into one
// instruction and hands it to the FIFO.
//   clk, rst       - clock, synchronous active-high reset
//   flush          - drop the partial / pending instruction
//   seg_data       - NUM_SEGS segments, segment k at [k*SEG_WIDTH +: SEG_WIDTH]
//   write_en       - per-segment write strobe
//   space_avail    - FIFO can take a push this edge (not full, or popping)
//   instr          - assembled instruction, including this cycle's writes
//   complete       - instr is pushed into the FIFO at this edge
//   wr_ready       - registered; low while a finished instruction waits
module instr_assembler
   import tpu_pkg::*;
#(
   parameter int INSTR_WIDTH = INSTR_TYPE_W,
   parameter int SEG_WIDTH   = DEFAULT_SEG_WIDTH,
   parameter int NUM_SEGS    = seg_count(INSTR_WIDTH, SEG_WIDTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_SEGS*SEG_WIDTH-1:0] seg_data,
   input  logic [NUM_SEGS-1:0]           write_en,
   input  logic                          space_avail,
   output logic [INSTR_WIDTH-1:0]        instr,
   output logic                          complete,
   output logic                          wr_ready
);

   logic [INSTR_WIDTH-1:0] instr_q;
   logic [NUM_SEGS-1:0]    valid_q;
   logic                   pending_q;
   logic [NUM_SEGS-1:0]    accept;
   logic [INSTR_WIDTH-1:0] mask;
   logic                   ready_to_push;

   // Bits of the top segment above INSTR_WIDTH are never stored.
   if (NUM_SEGS*SEG_WIDTH > INSTR_WIDTH) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^seg_data[NUM_SEGS*SEG_WIDTH-1:INSTR_WIDTH];
   end

   assign accept = write_en & {NUM_SEGS{wr_ready}};

   always_comb begin
      mask = '0;
      for (int b = 0; b < INSTR_WIDTH; b++)
         mask[b] = accept[b / SEG_WIDTH];
   end

   // Same-cycle writes are merged in so the completing edge pushes them.
   assign instr = (instr_q & ~mask) | (seg_data[INSTR_WIDTH-1:0] & mask);

   // While pending all valid bits stay set, so this stays true.
   assign ready_to_push = &(valid_q | accept);
   assign complete      = ready_to_push & space_avail & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q   <= '0;
         valid_q   <= '0;
         pending_q <= 1'b0;
         wr_ready  <= 1'b1;
      end else if (flush) begin
         valid_q   <= '0;
         pending_q <= 1'b0;
         wr_ready  <= 1'b1;
      end else begin
         instr_q <= instr;
         if (complete) begin
            valid_q   <= '0;
            pending_q <= 1'b0;
            wr_ready  <= 1'b1;
         end else if (ready_to_push) begin
            // Finished but no room: hold it and stall the host.
            valid_q   <= '1;
            pending_q <= 1'b1;
            wr_ready  <= 1'b0;
         end else begin
            valid_q   <= valid_q | accept;
         end
      end
   end

   // pending_q mirrors ~wr_ready; kept as explicit state for readability.
   logic unused_pending;
   assign unused_pending = pending_q;

endmodule

// File: rtl/instr_assembly_fifo.sv
// instr_assembly_fifo: segment assembler in front of a first-word-fall-through
// instruction FIFO feeding the TPU control unit.
//   clk, rst              - clock, synchronous active-high reset
//   seg_data, write_en    - host segment writes (see instr_assembler)
//   wr_ready              - segments are accepted this cycle
//   next_en               - pop the head entry
//   data_out              - head entry, combinational from the read pointer
//   flush                 - discard all entries and any partial instruction
//   empty/full/almost_full, count - occupancy status
//   overflow/underflow    - sticky error flags, cleared only by rst
module instr_assembly_fifo
   import tpu_pkg::*;
#(
   parameter int  FIFO_DEPTH        = 32,
   parameter int  INSTR_WIDTH       = INSTR_TYPE_W,
   parameter int  SEG_WIDTH         = DEFAULT_SEG_WIDTH,
   parameter int  ALMOST_FULL_LEVEL = FIFO_DEPTH - 4,
   localparam int NUM_SEGS          = seg_count(INSTR_WIDTH, SEG_WIDTH),
   localparam int AW                = $clog2(FIFO_DEPTH),
   localparam int CW                = AW + 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SEGS*SEG_WIDTH-1:0] seg_data,
   input  logic [NUM_SEGS-1:0]           write_en,
   output logic                          wr_ready,
   input  logic                          next_en,
   output logic [INSTR_WIDTH-1:0]        data_out,
   input  logic                          flush,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_full,
   output logic [CW-1:0]                 count,
   output logic                          overflow,
   output logic                          underflow
);

   logic [INSTR_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr, rd_ptr;
   logic [INSTR_WIDTH-1:0] instr;
   logic                   complete;
   logic                   pop_req, push, pop;

   assign empty       = (count == '0);
   assign full        = (count == CW'(FIFO_DEPTH));
   assign almost_full = (count >= CW'(ALMOST_FULL_LEVEL));

   // A pop frees a slot for a push at the same edge; no bypass when empty.
   assign pop_req = next_en & ~empty;
   assign pop     = pop_req & ~flush;
   assign push    = complete;  // already gated by flush in the assembler

   instr_assembler #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .SEG_WIDTH   (SEG_WIDTH),
      .NUM_SEGS    (NUM_SEGS)
   ) u_asm (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .seg_data    (seg_data),
      .write_en    (write_en),
      .space_avail (~full | pop_req),
      .instr       (instr),
      .complete    (complete),
      .wr_ready    (wr_ready)
   );

   // Storage has no reset so it can map to LUT-RAM.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= instr;
   end

   assign data_out = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (|write_en && !wr_ready) overflow  <= 1'b1;
         if (next_en && empty)       underflow <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

endmodule
